// File: rtl/noc_adapter_pkg.sv
// Shared sizing helpers for the multi-VC NoC ejection adapter.
// Used by noc_rr_arbiter and noc_outport_vc_handshake_adapter.
package noc_adapter_pkg;

    function automatic int vc_idx_w(input int num_vcs);
        return (num_vcs > 1) ? $clog2(num_vcs) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Highest count at which the NoC may still launch a flit.
    function automatic int avail_thresh(input int depth, input int flight);
        return depth - 1 - flight;
    endfunction

    localparam int DefNumVCs = 2;
    localparam int DefDepth  = 4;
    localparam int VcIdxW    = vc_idx_w(DefNumVCs);
    localparam int CntW      = cnt_w(DefDepth);

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last grant.
// Pointer resets to NumVCs-1 so VC0 wins first.
module noc_rr_arbiter
    import noc_adapter_pkg::*;
#(
    parameter int NumVCs = 2,
    localparam int IdxW = vc_idx_w(NumVCs)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumVCs-1:0] req,
    input  logic              adv,
    output logic [NumVCs-1:0] gnt,
    output logic [IdxW-1:0]   gnt_idx
);

    logic [IdxW-1:0] ptr;
    logic            found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NumVCs; i++) begin
            if (!found && req[i] && (i > int'(ptr))) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IdxW'(i);
            end
        end
        for (int i = 0; i < NumVCs; i++) begin
            if (!found && req[i] && (i <= int'(ptr))) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IdxW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IdxW'(NumVCs - 1);
        end else if (adv && found) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/noc_outport_vc_handshake_adapter.sv
// Multi-VC NoC ejection adapter: per-VC skid buffers merged by round robin.
// Optional sticky overflow detection: define NOC_OUTPORT_OVF_DETECT_EN.
module noc_outport_vc_handshake_adapter
    import noc_adapter_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int NumVCs     = 2,
    parameter int Depth      = 4,
    parameter int FlightTime = 2,
    localparam int IdxW = vc_idx_w(NumVCs)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 data_valid_i,
    input  logic [IdxW-1:0]      vc_i,
    output logic [NumVCs-1:0]    avail_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 data_valid_o,
    output logic [IdxW-1:0]      vc_o,
    input  logic                 full_i,
    output logic                 overflow_o
);

    localparam int BufCntW = cnt_w(Depth);
    localparam int PtrW    = $clog2(Depth);
    localparam logic [BufCntW-1:0] Thresh =
        BufCntW'(avail_thresh(Depth, FlightTime));
    localparam logic [BufCntW-1:0] Full = BufCntW'(Depth);

    logic [NumVCs-1:0]    req;
    logic [NumVCs-1:0]    gnt;
    logic [NumVCs-1:0]    wr_hit;
    logic [NumVCs-1:0]    pop_v;
    logic [IdxW-1:0]      gnt_idx;
    logic [DataWidth-1:0] head [NumVCs];
    logic [BufCntW-1:0]   count [NumVCs];
    logic                 load_en;
    logic                 pop;

    assign load_en = !data_valid_o || !full_i;
    assign pop     = load_en && (|req);

    for (genvar v = 0; v < NumVCs; v++) begin : g_vc
        logic [DataWidth-1:0] mem [Depth];
        logic [PtrW-1:0]      wr_ptr;
        logic [PtrW-1:0]      rd_ptr;
        logic [BufCntW-1:0]   cnt;
        logic                 do_wr;

        if (NumVCs == 1) begin : g_one
            logic unused_vc;
            assign unused_vc = ^vc_i;
            assign wr_hit[v] = data_valid_i;
        end else begin : g_many
            assign wr_hit[v] = data_valid_i && (vc_i == IdxW'(v));
        end

        assign do_wr      = wr_hit[v] && (cnt != Full);
        assign pop_v[v]   = pop && gnt[v];
        assign req[v]     = (cnt != '0);
        assign avail_o[v] = (cnt <= Thresh);
        assign count[v]   = cnt;
        assign head[v]    = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (do_wr) begin
                mem[wr_ptr] <= data_i;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (do_wr) begin
                    wr_ptr <= wr_ptr + PtrW'(1);
                end
                if (pop_v[v]) begin
                    rd_ptr <= rd_ptr + PtrW'(1);
                end
                unique case ({do_wr, pop_v[v]})
                    2'b10:   cnt <= cnt + BufCntW'(1);
                    2'b01:   cnt <= cnt - BufCntW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    noc_rr_arbiter #(
        .NumVCs(NumVCs)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .adv    (load_en),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid_o <= 1'b0;
            data_o       <= '0;
            vc_o         <= '0;
        end else if (load_en) begin
            if (|req) begin
                data_o       <= head[gnt_idx];
                vc_o         <= gnt_idx;
                data_valid_o <= 1'b1;
            end else begin
                data_valid_o <= 1'b0;
            end
        end
    end

`ifdef NOC_OUTPORT_OVF_DETECT_EN
    logic [NumVCs-1:0] ovf_ev;

    for (genvar v = 0; v < NumVCs; v++) begin : g_ovf
        assign ovf_ev[v] = wr_hit[v] && (count[v] == Full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (|ovf_ev) begin
            overflow_o <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < NumVCs; v++) begin
                if (ovf_ev[v]) begin
                    $error("noc adapter overflow on VC %0d", v);
                end
            end
        end
    end
`endif
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_outport_vc_handshake_adapter.sv
// Randomised and directed bench for noc_outport_vc_handshake_adapter.
// Reference model uses per-VC queues and a plain round-robin pointer.
module tb_noc_outport_vc_handshake_adapter;

    localparam int DW    = 32;
    localparam int NVC   = 2;
    localparam int DEPTH = 4;
    localparam int FT    = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  data_i;
    logic           data_valid_i;
    logic [0:0]     vc_i;
    logic [NVC-1:0] avail_o;
    logic [DW-1:0]  data_o;
    logic           data_valid_o;
    logic [0:0]     vc_o;
    logic           full_i;
    logic           overflow_o;

    int total = 0;
    int bad   = 0;

    noc_outport_vc_handshake_adapter #(
        .DataWidth (DW),
        .NumVCs    (NVC),
        .Depth     (DEPTH),
        .FlightTime(FT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .data_valid_i(data_valid_i),
        .vc_i        (vc_i),
        .avail_o     (avail_o),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .vc_o        (vc_o),
        .full_i      (full_i),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: queues per VC plus one output slot.
    logic [DW-1:0] mq [NVC][$];
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_vc;
    int            m_ptr;
    int            m_drops;

    always @(posedge clk) begin : model
        int  sz [NVC];
        int  g;
        bit  drop;
        if (rst) begin
            for (int v = 0; v < NVC; v++) mq[v].delete();
            m_valid = 0;
            m_data  = '0;
            m_vc    = 0;
            m_ptr   = NVC - 1;
            m_drops = 0;
        end else begin
            for (int v = 0; v < NVC; v++) sz[v] = mq[v].size();
            drop = data_valid_i && (sz[vc_i] == DEPTH);
            if (!m_valid || !full_i) begin
                g = -1;
                for (int i = 1; i <= NVC; i++) begin
                    if (g < 0 && sz[(m_ptr + i) % NVC] > 0) g = (m_ptr + i) % NVC;
                end
                if (g >= 0) begin
                    m_data  = mq[g].pop_front();
                    m_vc    = g;
                    m_valid = 1;
                    m_ptr   = g;
                end else begin
                    m_valid = 0;
                end
            end
            if (data_valid_i) begin
                if (drop) m_drops++;
                else mq[vc_i].push_back(data_i);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        data_valid_i = 1'b0;
        data_i       = '0;
        vc_i         = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        full_i = 1'b0;
        cyc();
        cyc();
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", data_valid_o); end
        total++; if (data_o !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
        total++; if (vc_o !== 1'b0) begin bad++; $display("FAIL reset_vc: got %b want 0", vc_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        total++; if (avail_o !== 2'b11) begin bad++; $display("FAIL reset_avail: got %b want 11", avail_o); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        full_i = 1'b0;
        idle();
        cyc();
        data_valid_i = 1'b1;
        vc_i         = 1'b1;
        data_i       = 32'hA5A5_0001;
        cyc();
        idle();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (data_valid_o !== (k == 1)) begin
                bad++; $display("FAIL single_valid[%0d]: got %b want %b", k, data_valid_o, k == 1);
            end
            if (k == 1) begin
                total++;
                if (data_o !== 32'hA5A5_0001 || vc_o !== 1'b1) begin
                    bad++; $display("FAIL single_data: got %h/%0d want a5a50001/1", data_o, vc_o);
                end
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        bit            av_hist[$];
        bit            go;
        int            sent;
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] got[$];
        sent = 0;
        av_hist = {1'b1, 1'b1};
        full_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            go = av_hist.pop_front();
            av_hist.push_back(avail_o[0]);
            if (go) begin
                data_valid_i = 1'b1;
                vc_i         = 1'b0;
                data_i       = $urandom;
                exp_q.push_back(data_i);
                sent++;
            end else begin
                idle();
            end
            cyc();
            total++;
            if (avail_o[0] !== (mq[0].size() <= DEPTH - 1 - FT)) begin
                bad++; $display("FAIL bp_avail[%0d]: got %b want %b", c, avail_o[0], mq[0].size() <= DEPTH - 1 - FT);
            end
        end
        idle();
        total++; if (sent != 5) begin bad++; $display("FAIL bp_sent: got %0d want 5", sent); end
        total++; if (data_valid_o !== 1'b1 || avail_o[0] !== 1'b0) begin
            bad++; $display("FAIL bp_state: got valid=%b avail=%b want 1/0", data_valid_o, avail_o[0]);
        end
        total++; if (overflow_o !== 1'b0 || m_drops != 0) begin
            bad++; $display("FAIL bp_ovf: got %b drops=%0d want 0", overflow_o, m_drops);
        end
        full_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (data_valid_o && !full_i) got.push_back(data_o);
            cyc();
        end
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL bp_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i] !== exp_q[i]) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] q0[$];
        logic [DW-1:0] q1[$];
        logic [DW-1:0] dummy;
        logic [DW-1:0] want;
        full_i = 1'b1;
        dummy = $urandom;
        data_valid_i = 1'b1; vc_i = 1'b1; data_i = dummy;
        cyc();
        for (int i = 0; i < 6; i++) begin
            data_valid_i = 1'b1;
            vc_i = i[0];
            data_i = $urandom;
            if (i[0]) q1.push_back(data_i); else q0.push_back(data_i);
            cyc();
        end
        idle();
        full_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) want = dummy;
            else if (i[0]) want = q0.pop_front();
            else want = q1.pop_front();
            total++;
            if (data_valid_o !== 1'b1 || vc_o !== (i == 0 ? 1'b1 : !i[0]) || data_o !== want) begin
                bad++; $display("FAIL rr[%0d]: got v=%b vc=%b d=%h want 1/%b/%h", i, data_valid_o, vc_o, data_o, (i == 0 ? 1'b1 : !i[0]), want);
            end
            cyc();
        end
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL rr_drain: got %b want 0", data_valid_o); end
    endtask

    task automatic test_stall_hold();
        logic [DW-1:0] f0;
        logic [DW-1:0] f1;
        f0 = $urandom;
        f1 = $urandom;
        full_i = 1'b1;
        data_valid_i = 1'b1; vc_i = 1'b0; data_i = f0;
        cyc();
        data_i = f1;
        cyc();
        idle();
        cyc();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (data_valid_o !== 1'b1 || data_o !== f0 || vc_o !== 1'b0) begin
                bad++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/%h", i, data_valid_o, data_o, f0);
            end
            cyc();
        end
        full_i = 1'b0;
        cyc();
        total++;
        if (data_valid_o !== 1'b1 || data_o !== f1) begin
            bad++; $display("FAIL stall_next: got %b/%h want 1/%h", data_valid_o, data_o, f1);
        end
        cyc();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] sent[$];
        logic [DW-1:0] got[$];
        bit            want_ovf;
`ifdef NOC_OUTPORT_OVF_DETECT_EN
        want_ovf = 1'b1;
`else
        want_ovf = 1'b0;
`endif
        full_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_valid_i = 1'b1; vc_i = 1'b0; data_i = $urandom;
            sent.push_back(data_i);
            cyc();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (overflow_o !== want_ovf) begin bad++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, overflow_o, want_ovf); end
        end
        full_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (data_valid_o && !full_i) got.push_back(data_o);
            cyc();
        end
        total++; if (got.size() != 5) begin bad++; $display("FAIL ovf_count: got %0d want 5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            total++;
            if (got[i] !== sent[i]) begin bad++; $display("FAIL ovf_order[%0d]: got %h want %h", i, got[i], sent[i]); end
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow_o); end
    endtask

    task automatic test_reset_mid();
        full_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_valid_i = 1'b1; vc_i = 1'($urandom_range(0, 1)); data_i = $urandom;
            cyc();
        end
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++;
        if (data_valid_o !== 1'b0 || avail_o !== 2'b11) begin
            bad++; $display("FAIL mid_reset: got v=%b avail=%b want 0/11", data_valid_o, avail_o);
        end
        full_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            total++;
            if (data_valid_o !== 1'b0) begin bad++; $display("FAIL mid_reset_emit[%0d]: got %b want 0", i, data_valid_o); end
        end
    endtask

    task automatic test_random();
        int v;
        for (int c = 0; c < 400; c++) begin
            full_i = ($urandom_range(0, 3) == 0);
            v = $urandom_range(0, NVC - 1);
            if ($urandom_range(0, 3) != 0 && mq[v].size() <= DEPTH - 1 - FT) begin
                data_valid_i = 1'b1; vc_i = 1'(v); data_i = $urandom;
            end else begin
                idle();
            end
            cyc();
            total++;
            if (data_valid_o !== m_valid) begin
                bad++; $display("FAIL rand_valid[%0d]: got %b want %b", c, data_valid_o, m_valid);
            end else if (m_valid && (data_o !== m_data || vc_o !== 1'(m_vc))) begin
                bad++; $display("FAIL rand_data[%0d]: got %h/%0d want %h/%0d", c, data_o, vc_o, m_data, m_vc);
            end
            for (int k = 0; k < NVC; k++) begin
                total++;
                if (avail_o[k] !== (mq[k].size() <= DEPTH - 1 - FT)) begin
                    bad++; $display("FAIL rand_avail[%0d][%0d]: got %b want %b", c, k, avail_o[k], mq[k].size() <= DEPTH - 1 - FT);
                end
            end
        end
        idle();
        full_i = 1'b0;
        for (int c = 0; c < 20; c++) cyc();
        total++; if (data_valid_o !== 1'b0 || m_drops != 0) begin
            bad++; $display("FAIL rand_drain: got v=%b drops=%0d want 0/0", data_valid_o, m_drops);
        end
    endtask

    initial begin
        rst = 1'b1;
        full_i = 1'b0;
        idle();
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_stall_hold();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
